// File: rtl/bus_pkg.sv
// Shared definitions for the bus master: FSM states, responder register
// addresses and the byte-enable qualifier used when a command is latched.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      STB  = 2'b10,
      END  = 2'b11
   } state_e;

   localparam logic [15:0] REG_CSR_ADDR  = 16'o177662;
   localparam logic [15:0] REG_DATA_ADDR = 16'o177664;

   // Reads never drive byte enables onto the bus.
   function automatic logic [1:0] bus_wtbt_f(input logic we, input logic [1:0] wtbt);
      logic [1:0] res;
      if (we) begin
         res = wtbt;
      end else begin
         res = 2'b00;
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_master_if.sv
// Bus signals between the master and its responders; din is the wired-OR
// of all responder outputs and ack may be combinational from stb.
interface bus_master_if;

   logic [15:0] addr;
   logic [15:0] dout;
   logic [15:0] din;
   logic        sync;
   logic        we;
   logic [1:0]  wtbt;
   logic        stb;
   logic        ack;

   modport master (
      output addr, dout, sync, we, wtbt, stb,
      input  din, ack
   );

   modport slave (
      input  addr, dout, sync, we, wtbt, stb,
      output din, ack
   );

endinterface

// File: rtl/bus_master.sv
// Single-transaction bus master: frames one command per IDLE-ADDR-STB-END
// sequence, abandoning it as an error after TIMEOUT unacknowledged strobes.
module bus_master
   import bus_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_addr,
   input  logic        cmd_we,
   input  logic [1:0]  cmd_wtbt,
   input  logic [15:0] cmd_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   bus_master_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_e           state_r;
   state_e           state_s;
   logic             accept_s;
   logic             ack_hit_s;
   logic             timeout_s;
   logic [CNT_W-1:0] cnt_r;

   logic [15:0]      bus_addr_r;
   logic [15:0]      bus_dout_r;
   logic             bus_sync_r;
   logic             bus_we_r;
   logic [1:0]       bus_wtbt_r;
   logic             bus_stb_r;

   logic             rsp_valid_r;
   logic [15:0]      rsp_data_r;
   logic             rsp_err_r;

   // Ready is gated by reset so it is low for every cycle reset is held.
   assign cmd_ready = (state_r == IDLE) & ~reset;

   // Next-state decode; the first strobe cycle (count 1) never samples ack.
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      ack_hit_s = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               state_s  = ADDR;
               accept_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         ADDR: begin
            state_s = STB;
         end
         STB: begin
            ack_hit_s = bus.ack & (cnt_r != CNT_ONE);
            timeout_s = (cnt_r == CNT_MAX);
            if (ack_hit_s || timeout_s) begin
               state_s = END;
            end else begin
               state_s = STB;
            end
         end
         END: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register and saturating strobe-cycle counter.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         if (state_s == STB) begin
            if (state_r != STB) begin
               cnt_r <= CNT_ONE;
            end else if (cnt_r == CNT_MAX) begin
               cnt_r <= cnt_r;
            end else begin
               cnt_r <= cnt_r + CNT_ONE;
            end
         end else begin
            cnt_r <= '0;
         end
      end
   end

   // Bus outputs are loaded straight from the command on accept and then
   // held, so they double as the command latch for the whole frame.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bus_addr_r <= 16'h0000;
         bus_dout_r <= 16'h0000;
         bus_we_r   <= 1'b0;
         bus_wtbt_r <= 2'b00;
         bus_sync_r <= 1'b0;
         bus_stb_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            bus_addr_r <= cmd_addr;
            bus_dout_r <= cmd_data;
            bus_we_r   <= cmd_we;
            bus_wtbt_r <= bus_wtbt_f(cmd_we, cmd_wtbt);
         end else if (state_s == IDLE) begin
            bus_addr_r <= 16'h0000;
            bus_dout_r <= 16'h0000;
            bus_we_r   <= 1'b0;
            bus_wtbt_r <= 2'b00;
         end else begin
            bus_addr_r <= bus_addr_r;
            bus_dout_r <= bus_dout_r;
            bus_we_r   <= bus_we_r;
            bus_wtbt_r <= bus_wtbt_r;
         end
         bus_sync_r <= (state_s != IDLE);
         bus_stb_r  <= (state_s == STB);
      end
   end

   // Response is presented only during END; ack takes priority over timeout.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_data_r  <= 16'h0000;
      end else if ((state_r == STB) && (state_s == END)) begin
         rsp_valid_r <= 1'b1;
         rsp_err_r   <= ~ack_hit_s;
         if (ack_hit_s && !bus_we_r) begin
            rsp_data_r <= bus.din;
         end else begin
            rsp_data_r <= 16'h0000;
         end
      end else begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_data_r  <= 16'h0000;
      end
   end

   assign bus.addr  = bus_addr_r;
   assign bus.dout  = bus_dout_r;
   assign bus.sync  = bus_sync_r;
   assign bus.we    = bus_we_r;
   assign bus.wtbt  = bus_wtbt_r;
   assign bus.stb   = bus_stb_r;

   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: three instances (default, TIMEOUT=8,
// TIMEOUT=4), each with its own small responder model.
module tb_bus_master;
   import bus_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        cv_a, cv_b, cv_c;
   logic [15:0] cmd_addr;
   logic        cmd_we;
   logic [1:0]  cmd_wtbt;
   logic [15:0] cmd_data;

   logic        rdy_a, rdy_b, rdy_c;
   logic        rv_a, rv_b, rv_c;
   logic [15:0] rd_a, rd_b, rd_c;
   logic        re_a, re_b, re_c;

   int n_cmp = 0;
   int n_mis = 0;

   bus_master_if bif_a ();
   bus_master_if bif_b ();
   bus_master_if bif_c ();

   always #5 clk_sys = ~clk_sys;

   bus_master dut_a (
      .clk_sys(clk_sys), .reset(reset),
      .cmd_valid(cv_a), .cmd_ready(rdy_a), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
      .cmd_wtbt(cmd_wtbt), .cmd_data(cmd_data),
      .rsp_valid(rv_a), .rsp_data(rd_a), .rsp_err(re_a), .bus(bif_a)
   );

   bus_master #(.TIMEOUT(8)) dut_b (
      .clk_sys(clk_sys), .reset(reset),
      .cmd_valid(cv_b), .cmd_ready(rdy_b), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
      .cmd_wtbt(cmd_wtbt), .cmd_data(cmd_data),
      .rsp_valid(rv_b), .rsp_data(rd_b), .rsp_err(re_b), .bus(bif_b)
   );

   bus_master #(.TIMEOUT(4)) dut_c (
      .clk_sys(clk_sys), .reset(reset),
      .cmd_valid(cv_c), .cmd_ready(rdy_c), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
      .cmd_wtbt(cmd_wtbt), .cmd_data(cmd_data),
      .rsp_valid(rv_c), .rsp_data(rd_c), .rsp_err(re_c), .bus(bif_c)
   );

   // Responder A: register at REG_DATA_ADDR, acks any address after ack_delay_a strobes.
   logic [15:0] reg_a = 16'h0000;
   int          stb_cnt_a = 0;
   int          ack_delay_a = 0;
   assign bif_a.ack = bif_a.stb && (stb_cnt_a >= ack_delay_a);
   assign bif_a.din = (bif_a.stb && !bif_a.we && bif_a.addr == REG_DATA_ADDR) ? reg_a : 16'h0000;
   always @(posedge clk_sys) begin
      stb_cnt_a <= bif_a.stb ? stb_cnt_a + 1 : 0;
      if (bif_a.stb && bif_a.ack && bif_a.we && bif_a.addr == REG_DATA_ADDR) begin
         if (bif_a.wtbt[0]) reg_a[7:0]  <= bif_a.dout[7:0];
         if (bif_a.wtbt[1]) reg_a[15:8] <= bif_a.dout[15:8];
      end
   end

   // Responder B: nothing mapped, never acks, but din carries junk.
   assign bif_b.ack = 1'b0;
   assign bif_b.din = 16'hA5A5;

   // Responder C: acks only in the very first strobe cycle.
   int stb_cnt_c = 0;
   assign bif_c.ack = bif_c.stb && (stb_cnt_c == 0);
   assign bif_c.din = bif_c.stb ? 16'h1234 : 16'h0000;
   always @(posedge clk_sys) stb_cnt_c <= bif_c.stb ? stb_cnt_c + 1 : 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      cv_a = 1'b0; cv_b = 1'b0; cv_c = 1'b0;
      cmd_addr = 16'h0000; cmd_we = 1'b0; cmd_wtbt = 2'b00; cmd_data = 16'h0000;

      // Reset state
      tick(); tick();
      check("rst_ready",  32'(rdy_a), 32'd0);
      check("rst_rvalid", 32'(rv_a), 32'd0);
      check("rst_sync",   32'(bif_a.sync), 32'd0);
      check("rst_stb",    32'(bif_a.stb), 32'd0);
      check("rst_addr",   32'(bif_a.addr), 32'd0);
      check("rst_err",    32'(re_a), 32'd0);
      check("rst_data",   32'(rd_a), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_ready_after_a", 32'(rdy_a), 32'd1);
      check("rst_ready_after_b", 32'(rdy_b), 32'd1);

      // Write 16'o001330 to the data register, combinational ack
      cmd_addr = REG_DATA_ADDR; cmd_we = 1'b1; cmd_wtbt = 2'b11; cmd_data = 16'o001330;
      ack_delay_a = 0;
      cv_a = 1'b1;
      check("wr_ready_n", 32'(rdy_a), 32'd1);
      tick(); cv_a = 1'b0;
      check("wr_addr_sync", 32'(bif_a.sync), 32'd1);
      check("wr_addr_stb",  32'(bif_a.stb), 32'd0);
      check("wr_addr",      32'(bif_a.addr), 32'(REG_DATA_ADDR));
      check("wr_we",        32'(bif_a.we), 32'd1);
      check("wr_wtbt",      32'(bif_a.wtbt), 32'd3);
      check("wr_dout",      32'(bif_a.dout), 32'(16'o001330));
      check("wr_ready_n1",  32'(rdy_a), 32'd0);
      tick();
      check("wr_stb_n2",  32'(bif_a.stb), 32'd1);
      check("wr_sync_n2", 32'(bif_a.sync), 32'd1);
      tick();
      check("wr_stb_n3",  32'(bif_a.stb), 32'd1);
      check("wr_rv_n3",   32'(rv_a), 32'd0);
      tick();
      check("wr_rv_n4",   32'(rv_a), 32'd1);
      check("wr_err_n4",  32'(re_a), 32'd0);
      check("wr_data_n4", 32'(rd_a), 32'd0);
      check("wr_stb_n4",  32'(bif_a.stb), 32'd0);
      check("wr_sync_n4", 32'(bif_a.sync), 32'd1);
      tick();
      check("wr_rv_n5",    32'(rv_a), 32'd0);
      check("wr_sync_n5",  32'(bif_a.sync), 32'd0);
      check("wr_ready_n5", 32'(rdy_a), 32'd1);
      check("wr_idle_addr", 32'(bif_a.addr), 32'd0);
      check("wr_idle_dout", 32'(bif_a.dout), 32'd0);
      check("wr_reg",      32'(reg_a), 32'(16'o001330));

      // Read with ack delayed 5 strobe cycles
      cmd_addr = REG_DATA_ADDR; cmd_we = 1'b0; cmd_wtbt = 2'b11; cmd_data = 16'o007777;
      ack_delay_a = 5;
      cv_a = 1'b1;
      tick(); cv_a = 1'b0;
      check("rd_we",   32'(bif_a.we), 32'd0);
      check("rd_wtbt", 32'(bif_a.wtbt), 32'd0);
      check("rd_sync", 32'(bif_a.sync), 32'd1);
      for (int i = 2; i <= 7; i++) begin
         tick();
         check("rd_stb_hold", 32'(bif_a.stb), 32'd1);
         check("rd_rv_early", 32'(rv_a), 32'd0);
      end
      tick();
      check("rd_rv_n8",   32'(rv_a), 32'd1);
      check("rd_data_n8", 32'(rd_a), 32'(16'o001330));
      check("rd_err_n8",  32'(re_a), 32'd0);
      tick();

      // Back-to-back: low-byte write then read, cmd_valid held high
      ack_delay_a = 0;
      cmd_addr = REG_DATA_ADDR; cmd_we = 1'b1; cmd_wtbt = 2'b01; cmd_data = 16'h0053;
      cv_a = 1'b1;
      check("b2b_ready_n", 32'(rdy_a), 32'd1);
      tick();
      check("b2b_wtbt",    32'(bif_a.wtbt), 32'd1);
      check("b2b_busy_n1", 32'(rdy_a), 32'd0);
      tick(); tick(); tick();
      check("b2b_rv_n4",   32'(rv_a), 32'd1);
      tick();
      check("b2b_sync_n5",  32'(bif_a.sync), 32'd0);
      check("b2b_ready_n5", 32'(rdy_a), 32'd1);
      cmd_we = 1'b0; cmd_wtbt = 2'b00;
      tick(); cv_a = 1'b0;
      check("b2b_sync_n6", 32'(bif_a.sync), 32'd1);
      check("b2b_we_n6",   32'(bif_a.we), 32'd0);
      tick(); tick(); tick();
      check("b2b_rv_n9",   32'(rv_a), 32'd1);
      check("b2b_data_n9", 32'(rd_a), 32'h0253);
      tick();

      // Reset during the second strobe cycle
      ack_delay_a = 100;
      cmd_addr = REG_DATA_ADDR; cmd_we = 1'b0; cmd_wtbt = 2'b00;
      cv_a = 1'b1;
      tick(); cv_a = 1'b0;
      tick(); tick();
      check("rst_mid_stb", 32'(bif_a.stb), 32'd1);
      reset = 1'b1;
      tick();
      check("rst_mid_stb_drop",  32'(bif_a.stb), 32'd0);
      check("rst_mid_sync_drop", 32'(bif_a.sync), 32'd0);
      check("rst_mid_rv",        32'(rv_a), 32'd0);
      check("rst_mid_ready",     32'(rdy_a), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_mid_ready_after", 32'(rdy_a), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_mid_no_rv", 32'(rv_a), 32'd0);
      end

      // TIMEOUT=8: unmapped read, no ack
      cmd_addr = 16'o177000; cmd_we = 1'b0; cmd_wtbt = 2'b00;
      cv_b = 1'b1;
      tick(); cv_b = 1'b0;
      check("to8_sync", 32'(bif_b.sync), 32'd1);
      check("to8_addr_stb", 32'(bif_b.stb), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("to8_stb", 32'(bif_b.stb), 32'd1);
         check("to8_rv_early", 32'(rv_b), 32'd0);
      end
      tick();
      check("to8_stb_end", 32'(bif_b.stb), 32'd0);
      check("to8_rv",      32'(rv_b), 32'd1);
      check("to8_err",     32'(re_b), 32'd1);
      check("to8_data",    32'(rd_b), 32'd0);
      tick();
      check("to8_idle_sync", 32'(bif_b.sync), 32'd0);

      // TIMEOUT=4: ack only in first strobe cycle is ignored
      cmd_addr = REG_CSR_ADDR;
      cv_c = 1'b1;
      tick(); cv_c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("to4_stb", 32'(bif_c.stb), 32'd1);
      end
      tick();
      check("to4_rv",   32'(rv_c), 32'd1);
      check("to4_err",  32'(re_c), 32'd1);
      check("to4_data", 32'(rd_c), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter TIMEOUT, default 64: number of strobe cycles without acknowledge before a transaction is abandoned as a bus error.
REQ-002 clk_sys  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  host requests a bus transaction.
REQ-005 cmd_ready  out  1  block is idle and can accept a command.
REQ-006 cmd_addr  in  16  word/byte address of the transaction.
REQ-007 cmd_we  in  1  1 = write, 0 = read.
REQ-008 cmd_wtbt  in  2  write byte enables; [0] = low byte, [1] = high byte.
REQ-009 cmd_data  in  16  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse when a transaction completes.
REQ-011 rsp_data  out  16  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  transaction timed out; valid with rsp_valid.
REQ-013 bus_addr  out  16  address to responders.
REQ-014 bus_dout  out  16  write data to responders.
REQ-015 bus_din  in  16  read data from responders; this is the OR of all responder outputs.
REQ-016 bus_sync  out  1  address phase and transaction frame.
REQ-017 bus_we  out  1  write qualifier.
REQ-018 bus_wtbt  out  2  byte enables.
REQ-019 bus_stb  out  1  data strobe.
REQ-020 bus_ack  in  1  responder acknowledge; may be combinational from bus_stb.

Function
REQ-021 The state machine SHALL use the states IDLE, ADDR, STB and END.
REQ-022 cmd_ready SHALL be 1 only in IDLE.
REQ-023 A command is accepted when cmd_valid & cmd_ready; the block then latches addr, we, wtbt and data and moves to ADDR.
REQ-024 ADDR lasts one cycle with bus_sync=1, bus_stb=0, and bus_addr, bus_we and bus_dout driven from the latched values.
REQ-025 bus_wtbt SHALL be the latched wtbt for writes and 2'b00 for reads.
REQ-026 In STB, bus_stb=1 and bus_sync=1, and all bus outputs SHALL be stable.
REQ-027 bus_ack SHALL be ignored in the first STB cycle, so that responders can edge-detect the strobe; acknowledge is sampled from the second STB cycle onward.
REQ-028 On a sampled acknowledge, a read captures bus_din into rsp_data and the block moves to END with rsp_err=0.
REQ-029 A strobe-cycle counter SHALL count from 1 on STB entry; if the counter reaches TIMEOUT with no sampled acknowledge, the block moves to END with rsp_err=1 and rsp_data=0.
REQ-030 If acknowledge and timeout coincide in the same cycle, acknowledge wins.
REQ-031 END lasts one cycle with bus_stb=0, bus_sync=1 and rsp_valid=1, then returns to IDLE.
REQ-032 In IDLE, bus_sync, bus_stb, bus_we and bus_wtbt SHALL be 0, and bus_addr and bus_dout SHALL be 0.
REQ-033 Minimum latency from accept cycle N SHALL be: ADDR at N+1, STB at N+2..N+3, rsp_valid at N+4, next accept at N+5.
REQ-034 bus_sync SHALL be low for at least one cycle between consecutive transactions.
REQ-035 cmd_* inputs SHALL be ignored outside IDLE.
REQ-036 The counter width SHALL be $clog2(TIMEOUT+1), and the counter SHALL saturate rather than wrap.

Reset
REQ-037 While reset is asserted, the block SHALL go to IDLE on the next edge, and all bus outputs, rsp_valid, rsp_err, rsp_data and the counter SHALL become 0.
REQ-038 A reset mid-transaction SHALL abort the transaction with no rsp_valid, and bus_stb/bus_sync SHALL drop on the next edge.
REQ-039 cmd_ready SHALL be 0 while reset is asserted and 1 on the first cycle after reset deasserts.

Structure
REQ-040 The shared package bus_pkg SHALL hold the state enum and register address constants (16'o177662, 16'o177664).
REQ-041 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-042 Write 16'o001330 to 16'o177664 with wtbt=2'b11, responder acking combinationally -> bus_sync 1 cycle before bus_stb, bus_stb high 2 cycles, rsp_valid at N+4, rsp_err=0, responder register = 16'o001330.
REQ-043 Read 16'o177664 with acknowledge delayed 5 strobe cycles, bus_din=16'o001330 -> rsp_data=16'o001330, rsp_valid at N+8.
REQ-044 TIMEOUT=8, read of an unmapped address with no acknowledge -> bus_stb high exactly 8 cycles, rsp_err=1, rsp_data=0.
REQ-045 Reset asserted in the 2nd STB cycle -> bus_stb=bus_sync=0 next cycle, no rsp_valid, cmd_ready=1 after reset deasserts.
REQ-046 cmd_valid held high for 2 commands -> second accepted at N+5, bus_sync low at N+5.
REQ-047 Acknowledge pulsed only in the first STB cycle with TIMEOUT=4 -> ignored, rsp_err=1.
